tick_gen_multi: RTL and testbench
=================================

# tick_gen_multi

Multi-channel programmable tick generator: a parametrised successor to the team's fixed-period single tick counter. Each of NUM_CH independent channels divides `clk` by a runtime-loadable period, supports per-channel enable/pause, and runs in periodic or one-shot mode. It sits beside the system clock and feeds single-cycle `tic` strobes to debouncers, display scan logic and timeout logic.

## Interface
- `NUM_CH`, 4: number of independent channels (1..16).
- `WIDTH`, 17: period/count width in bits.
- `DEFAULT_PERIOD`, 99_999: period register value after reset. The channel ticks every DEFAULT_PERIOD+1 cycles.
- `PRESCALE`, 10: shared prescaler ratio. Used only when `TICK_GEN_PRESCALE_EN` is defined.
---
- `clk`, in, 1: clock. Rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `en`, in, NUM_CH: per-channel run enable.
- `mode`, in, NUM_CH: per-channel mode. 0 = periodic, 1 = one-shot. Sampled every cycle.
- `load`, in, 1: single-cycle period load strobe.
- `load_ch`, in, $clog2(NUM_CH) (minimum 1): channel index for `load`.
- `load_val`, in, WIDTH: new period value.
- `tic`, out, NUM_CH: registered one-cycle tick per channel.
- `busy`, out, NUM_CH: channel is in RUN.

## Operation
- Per-channel state is one of IDLE, RUN or DONE. Each channel has a `count` register and a `period` register.
- State transitions:
  - IDLE→RUN when `en`=1.
  - RUN→IDLE when `en`=0. This pauses the channel: `count` holds its value and counting resumes from it on re-enable.
  - RUN→DONE at terminal count when `mode`=1.
  - DONE→IDLE when `en`=0. DONE ignores `en`=1 otherwise.
- RUN behaviour on an advance cycle:
  - If `count`==`period`: `count`←0 and `tic`←1.
  - Otherwise: `count`←`count`+1 and `tic`←0.
- `tic` is 0 in every other case.
- `busy`=1 only in RUN.
- Period semantics: the tick interval is `period`+1 advance cycles. `period`=0 in periodic mode gives `tic` high on every advance cycle.
- Count arithmetic is unsigned WIDTH-bit. Because `count` resets to 0 at terminal count, it never wraps.
- Load behaviour: when `load`=1 and `load_ch`<NUM_CH, that channel gets `period`←`load_val` and `count`←0. A loaded channel in DONE returns to IDLE. Its state otherwise is unchanged.
- A `load_ch`≥NUM_CH is ignored.
- Load coinciding with terminal count: the load wins. No `tic` is issued and `count`←0.
- Load with `load_val` below the current `count`: takes effect cleanly, because the restart sets `count` to 0.
- Changing `mode` mid-RUN takes effect at the next terminal count.

## Timing
- Reset values: `tic`=0, `busy`=0, state IDLE, `count`=0, `period`=DEFAULT_PERIOD.
- Reset has priority over all other inputs, including `load`. It applies on the next rising edge.
- `en` asserted at edge k puts the channel in RUN after edge k, so `busy` is high in cycle k+1.
  - With no prescaler, the first `tic` is high in cycle k+P+1 and lasts exactly one cycle, where P = `period`.
  - Subsequent ticks in periodic mode follow every P+1 cycles.
- Load latency: `load` sampled at edge k means the new period governs counting from cycle k+1.
- Pause: `en` low at edge k means no increment at edge k.
- Ticks of different channels are fully independent and may coincide.

## Configuration
- Macro: `TICK_GEN_PRESCALE_EN`.
- Defined: a single shared prescaler counter (0..PRESCALE-1, free-running from reset, not affected by `en`) generates an advance strobe once every PRESCALE cycles. Channels in RUN advance only on that strobe, and `tic` can only assert in the cycle after a strobe. State transitions on `en` and `load` remain immediate.
- Undefined: every cycle is an advance cycle, and the PRESCALE parameter is unused.

## Structure
- Package `tick_gen_pkg` holds:
  - the channel state enum `tick_state_t` (IDLE, RUN, DONE);
  - the mode encoding constants `TICK_MODE_PERIODIC`=0 and `TICK_MODE_ONESHOT`=1.
- Sub-module `tick_channel` implements one channel: its state, count, period, `tic` and `busy`. Its inputs are `en`, `mode`, a channel-local `load`/`load_val` pair and the `adv` strobe.
- The top level `tick_gen_multi` holds:
  - the `generate` loop of channels;
  - `load_ch` decoding and the range check;
  - the optional prescaler.

## Test plan
- Reset with NUM_CH=4, then `en`=4'b0001: channel 0 `tic` fires in cycle 100_000 after enable, then every 100_000 cycles. Other channels keep `tic`=0 and `busy`=0.
- Load channel 2 with `load_val`=3 and set `en[2]`=1 in periodic mode: `tic[2]` is high every 4th cycle and one cycle wide. Then load `load_val`=0: `tic[2]` is high every cycle.
- One-shot on channel 1 with period 5: exactly one `tic` 6 cycles after enable, then `busy`=0 and no further ticks while `en` stays 1. Toggling `en` 0→1 produces one more tick.
- Pause and resume on channel 0 with period 9: drop `en` for 7 cycles at `count`=4. The tick is delayed by exactly 7 cycles. Issuing `load` in the same cycle as the terminal count suppresses that tick and restarts the count from 0.
- `load_ch`=5 with NUM_CH=4 leaves all periods unchanged. Asserting `rst` mid-count clears `tic`, `busy` and `count` and restores all periods to 99_999 on the next edge.
- With `TICK_GEN_PRESCALE_EN`, PRESCALE=10 and period 2: ticks are spaced 30 cycles apart, each one cycle wide.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared definitions for the multi-channel tick generator: channel state
// encoding and the meaning of the per-channel mode bit.
package tick_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tick_state_t;

  localparam logic TICK_MODE_PERIODIC = 1'b0;
  localparam logic TICK_MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: holds its own period and count, and emits a registered
// single-cycle tic each time the count reaches the period on an advance cycle.
// A one-shot channel parks in DONE after its tick until en is dropped or the
// channel is reloaded.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int          WIDTH          = 17,
  parameter int unsigned DEFAULT_PERIOD = 99_999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             adv,
  output logic             tic,
  output logic             busy
);

  localparam logic [WIDTH-1:0] RESET_PERIOD = WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0] ONE          = WIDTH'(1);

  tick_state_t      state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] period;

  // Channel state, count, period and tic; a load restarts the count and beats any terminal-count tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      period <= RESET_PERIOD;
      tic    <= 1'b0;
    end else begin
      tic <= 1'b0;
      if (load) begin
        period <= load_val;
        count  <= '0;
        if (state == DONE) begin
          state <= IDLE;
        end
      end else begin
        case (state)
          IDLE: begin
            if (en) begin
              state <= RUN;
            end
          end
          RUN: begin
            if (!en) begin
              state <= IDLE;
            end else if (adv) begin
              if (count == period) begin
                count <= '0;
                tic   <= 1'b1;
                if (mode == TICK_MODE_ONESHOT) begin
                  state <= DONE;
                end
              end else begin
                count <= count + ONE;
              end
            end
          end
          DONE: begin
            if (!en) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator. NUM_CH independent channels each
// divide clk by a runtime-loadable period. The load strobe is steered to one
// channel by load_ch; indices with no matching channel are dropped.
// Optional feature macro TICK_GEN_PRESCALE_EN: a shared free-running prescaler
// lets running channels advance only once every PRESCALE cycles. Without it,
// every cycle is an advance cycle.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int          NUM_CH         = 4,
  parameter int          WIDTH          = 17,
  parameter int unsigned DEFAULT_PERIOD = 99_999,
  parameter int          PRESCALE       = 10,
  localparam int         LCW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] mode,
  input  logic              load,
  input  logic [LCW-1:0]    load_ch,
  input  logic [WIDTH-1:0]  load_val,
  output logic [NUM_CH-1:0] tic,
  output logic [NUM_CH-1:0] busy
);

  logic adv;

`ifdef TICK_GEN_PRESCALE_EN
  localparam int             PSW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

  logic [PSW-1:0] psc;

  // Shared prescaler, free-running from reset regardless of any channel enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      psc <= '0;
    end else if (psc == PS_LAST) begin
      psc <= '0;
    end else begin
      psc <= psc + PSW'(1);
    end
  end

  assign adv = (psc == PS_LAST);
`else
  assign adv = 1'b1;
`endif

  // Each channel compares load_ch against its own index, so an index with no
  // channel behind it selects nothing.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_load;

    assign ch_load = load && (load_ch == LCW'(i));

    tick_channel #(
      .WIDTH         (WIDTH),
      .DEFAULT_PERIOD(DEFAULT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .mode    (mode[i]),
      .load    (ch_load),
      .load_val(load_val),
      .adv     (adv),
      .tic     (tic[i]),
      .busy    (busy[i])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi. The main instance uses a short default
// period (99, so ticks every 100 cycles) to keep run time small; a second
// 3-channel instance exercises a load_ch value with no channel behind it,
// which a 4-channel instance cannot encode on its 2-bit load_ch.
// Inputs change on the falling edge; outputs are read on the falling edge.
module tb_tick_gen_multi;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 17;
  localparam int DEF_P  = 99;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] mode;
  logic              load;
  logic [1:0]        load_ch;
  logic [WIDTH-1:0]  load_val;
  logic [NUM_CH-1:0] tic;
  logic [NUM_CH-1:0] busy;

  logic [2:0] en3;
  logic [2:0] mode3;
  logic       load3;
  logic [1:0] load_ch3;
  logic [7:0] load_val3;
  logic [2:0] tic3;
  logic [2:0] busy3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tick_gen_multi #(
    .NUM_CH        (NUM_CH),
    .WIDTH         (WIDTH),
    .DEFAULT_PERIOD(DEF_P),
    .PRESCALE      (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .load    (load),
    .load_ch (load_ch),
    .load_val(load_val),
    .tic     (tic),
    .busy    (busy)
  );

  tick_gen_multi #(
    .NUM_CH        (3),
    .WIDTH         (8),
    .DEFAULT_PERIOD(6),
    .PRESCALE      (10)
  ) dut3 (
    .clk     (clk),
    .rst     (rst),
    .en      (en3),
    .mode    (mode3),
    .load    (load3),
    .load_ch (load_ch3),
    .load_val(load_val3),
    .tic     (tic3),
    .busy    (busy3)
  );

  // Single comparison point: counts it and reports any disagreement.
  task automatic check_output(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Move k cycles forward; afterwards outputs reflect the last edge crossed.
  task automatic next_cycle(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Cycles from the current observation point until tic[ch] is seen; -1 on timeout.
  task automatic wait_tic(input int ch, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (tic[ch]) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int cnt;
    rst       = 1'b1;
    en        = '0;
    mode      = '0;
    load      = 1'b0;
    load_ch   = '0;
    load_val  = '0;
    en3       = '0;
    mode3     = '0;
    load3     = 1'b0;
    load_ch3  = '0;
    load_val3 = '0;
    next_cycle(2);
    rst = 1'b0;
    next_cycle(1);

    check_output("reset_tic", int'(tic), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_tic3", int'(tic3), 0);

`ifdef TICK_GEN_PRESCALE_EN
    // Period 2 with a divide-by-10 prescaler: 3 advances per tick, 30 cycles apart.
    load = 1'b1; load_ch = 2'd0; load_val = 17'd2;
    next_cycle(1);
    load = 1'b0; en = 4'b0001;
    next_cycle(1);
    check_output("ps_busy", int'(busy), 1);
    wait_tic(0, 100, n);
    check_output("ps_first_seen", int'(n > 0), 1);
    next_cycle(1);
    check_output("ps_width", int'(tic[0]), 0);
    wait_tic(0, 100, n);
    check_output("ps_spacing_a", n, 29);
    wait_tic(0, 100, n);
    check_output("ps_spacing_b", n, 30);
    next_cycle(1);
    check_output("ps_width_b", int'(tic[0]), 0);
`else
    // Channel 0 at the default period: first tick P+1 cycles after the enable edge.
    en = 4'b0001;
    next_cycle(1);
    check_output("ch0_busy_on", int'(busy), 1);
    wait_tic(0, 300, n);
    check_output("ch0_first_tic", n, DEF_P + 1);
    check_output("ch0_tic_only", int'(tic), 1);
    check_output("others_idle", int'(busy), 1);
    next_cycle(1);
    check_output("ch0_tic_width", int'(tic), 0);
    wait_tic(0, 300, n);
    check_output("ch0_period", n, DEF_P);
    en = 4'b0000;
    next_cycle(1);

    // Channel 2 with period 3, then period 0 loaded while running.
    load = 1'b1; load_ch = 2'd2; load_val = 17'd3;
    next_cycle(1);
    load = 1'b0; en = 4'b0100;
    next_cycle(1);
    wait_tic(2, 50, n);
    check_output("ch2_first", n, 4);
    check_output("ch2_tic_only", int'(tic), 4);
    next_cycle(1);
    check_output("ch2_width", int'(tic[2]), 0);
    wait_tic(2, 50, n);
    check_output("ch2_spacing", n, 3);
    load = 1'b1; load_ch = 2'd2; load_val = 17'd0;
    next_cycle(1);
    load = 1'b0;
    check_output("ch2_load_no_tic", int'(tic[2]), 0);
    for (int i = 0; i < 3; i++) begin
      next_cycle(1);
      check_output("ch2_p0_every", int'(tic[2]), 1);
    end
    en = 4'b0000;
    next_cycle(1);
    check_output("ch2_stopped_busy", int'(busy), 0);
    check_output("ch2_stopped_tic", int'(tic), 0);

    // Channel 1 one-shot with period 5, then re-armed by toggling en.
    load = 1'b1; load_ch = 2'd1; load_val = 17'd5;
    next_cycle(1);
    load = 1'b0; mode = 4'b0010; en = 4'b0010;
    next_cycle(1);
    wait_tic(1, 50, n);
    check_output("ch1_oneshot", n, 6);
    check_output("ch1_done_not_busy", int'(busy[1]), 0);
    cnt = 0;
    repeat (20) begin
      next_cycle(1);
      if (tic[1]) cnt++;
    end
    check_output("ch1_no_retrigger", cnt, 0);
    check_output("ch1_still_done", int'(busy), 0);
    en = 4'b0000;
    next_cycle(1);
    en = 4'b0010;
    next_cycle(1);
    wait_tic(1, 50, n);
    check_output("ch1_rearm", n, 6);
    en = 4'b0000; mode = 4'b0000;
    next_cycle(1);

    // Channel 0 period 9, paused at count 4: six low edges plus the re-entry
    // edge cost seven advances, so the tick moves from +10 to +17.
    load = 1'b1; load_ch = 2'd0; load_val = 17'd9;
    next_cycle(1);
    load = 1'b0; en = 4'b0001;
    next_cycle(1);
    next_cycle(4);
    en = 4'b0000;
    next_cycle(6);
    check_output("ch0_paused", int'(busy[0]), 0);
    en = 4'b0001;
    next_cycle(1);
    wait_tic(0, 50, n);
    check_output("ch0_pause_delay", n, 6);

    // Load landing on the terminal-count edge suppresses that tick.
    next_cycle(9);
    load = 1'b1; load_ch = 2'd0; load_val = 17'd2;
    next_cycle(1);
    load = 1'b0;
    check_output("ch0_load_beats_tic", int'(tic[0]), 0);
    wait_tic(0, 50, n);
    check_output("ch0_restart", n, 3);

    // Load to a channel index that does not exist leaves every period at 6.
    load3 = 1'b1; load_ch3 = 2'd3; load_val3 = 8'd1;
    next_cycle(1);
    load3 = 1'b0; en3 = 3'b111;
    next_cycle(1);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      next_cycle(1);
      if (tic3 != 3'b000) begin
        n = i;
        break;
      end
    end
    check_output("oor_period_kept", n, 7);
    check_output("oor_all_channels", int'(tic3), 7);

    // Reset mid-count, with a load pending, restores every channel.
    next_cycle(1);
    rst = 1'b1; load = 1'b1; load_ch = 2'd2; load_val = 17'd1;
    next_cycle(1);
    check_output("rst_tic", int'(tic), 0);
    check_output("rst_busy", int'(busy), 0);
    rst = 1'b0; load = 1'b0; en = 4'b1111;
    next_cycle(1);
    wait_tic(0, 300, n);
    check_output("rst_period_ch0", n, DEF_P + 1);
    check_output("rst_all_periods", int'(tic), 15);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
